// File: rtl/wf_mask_file_rr.sv
// ---------------------------------------------------------------------------
// wf_mask_file_rr
//
// Per-wavefront mask/state register file. Holds NUM_WF entries of DATA_W bits.
// Writers:
//   - one fetch init write, never stalled
//   - NUM_WR ALU write ports behind a round-robin arbiter (valid/ready),
//     at most one granted per cycle
// Readers:
//   - NUM_RD registered read ports, write-first bypass from both writers
// Every granted port write is reported to issue one cycle later on commit_*.
// Any write or read whose wfid lies outside the file sets the sticky err_oob.
//
// Ports
//   clk           clock, all state on the rising edge
//   rst           synchronous reset, active low
//   init_en       init write strobe
//   init_wfid     init target entry
//   init_data     init value
//   wr_valid      per-port write request
//   wr_wfid       per-port target, port p at [p*WFID_W +: WFID_W]
//   wr_data       per-port data, port p at [p*DATA_W +: DATA_W]
//   wr_ready      per-port grant (one-hot or zero)
//   rd_en         per-port read request
//   rd_wfid       per-port read address
//   rd_data       per-port read result, valid one cycle after rd_en
//   rd_valid      rd_en delayed one cycle
//   commit_valid  a port write committed on the previous edge
//   commit_wfid   target of that commit
//   commit_port   port index of that commit
//   err_oob       sticky out-of-range access flag
// ---------------------------------------------------------------------------
module wf_mask_file_rr #(
    parameter int NUM_WF = 40,
    parameter int WFID_W = 6,
    parameter int DATA_W = 64,
    parameter int NUM_WR = 8,
    parameter int NUM_RD = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       init_en,
    input  logic [WFID_W-1:0]          init_wfid,
    input  logic [DATA_W-1:0]          init_data,
    input  logic [NUM_WR-1:0]          wr_valid,
    input  logic [NUM_WR*WFID_W-1:0]   wr_wfid,
    input  logic [NUM_WR*DATA_W-1:0]   wr_data,
    output logic [NUM_WR-1:0]          wr_ready,
    input  logic [NUM_RD-1:0]          rd_en,
    input  logic [NUM_RD*WFID_W-1:0]   rd_wfid,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_valid,
    output logic                       commit_valid,
    output logic [WFID_W-1:0]          commit_wfid,
    output logic [$clog2(NUM_WR)-1:0]  commit_port,
    output logic                       err_oob
);

    localparam int PTR_W = $clog2(NUM_WR);

    // Widened compare so that NUM_WF == 2**WFID_W still works.
    function automatic logic in_range(input logic [WFID_W-1:0] w);
        return {1'b0, w} < (WFID_W+1)'(NUM_WF);
    endfunction

    logic [DATA_W-1:0] mem [NUM_WF];
    logic [PTR_W-1:0]  ptr;

    // ---------------------------------------------------------------------
    // Round-robin arbitration
    // ---------------------------------------------------------------------
    logic              cand_found;
    logic [PTR_W-1:0]  cand_idx;
    logic [PTR_W:0]    scan_idx;
    logic [WFID_W-1:0] cand_wfid;
    logic [DATA_W-1:0] cand_data;
    logic [PTR_W-1:0]  ptr_next;
    logic              grant;
    logic              init_in;
    logic              cand_in;

    always_comb begin
        cand_found = 1'b0;
        cand_idx   = '0;
        scan_idx   = '0;
        for (int i = 0; i < NUM_WR; i++) begin
            scan_idx = {1'b0, ptr} + (PTR_W+1)'(i);
            if (scan_idx >= (PTR_W+1)'(NUM_WR)) begin
                scan_idx = scan_idx - (PTR_W+1)'(NUM_WR);
            end
            if (!cand_found && wr_valid[scan_idx[PTR_W-1:0]]) begin
                cand_found = 1'b1;
                cand_idx   = scan_idx[PTR_W-1:0];
            end
        end
    end

    assign cand_wfid = wr_wfid[cand_idx*WFID_W +: WFID_W];
    assign cand_data = wr_data[cand_idx*DATA_W +: DATA_W];
    assign init_in   = in_range(init_wfid);
    assign cand_in   = in_range(cand_wfid);

    // Init owns the entry when both target it; the port simply retries.
    assign grant = rst && cand_found && !(init_en && (init_wfid == cand_wfid));

    assign wr_ready = grant ? (NUM_WR'(1) << cand_idx) : '0;

    assign ptr_next = (cand_idx == PTR_W'(NUM_WR - 1)) ? '0 : cand_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr          <= '0;
            commit_valid <= 1'b0;
            commit_wfid  <= '0;
            commit_port  <= '0;
        end else begin
            commit_valid <= grant;
            if (grant) begin
                ptr         <= ptr_next;
                commit_wfid <= cand_wfid;
                commit_port <= cand_idx;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Storage. Init and a granted port never share a wfid in one cycle,
    // so the two writes are independent.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_WF; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (init_en && init_in) begin
                mem[init_wfid] <= init_data;
            end
            if (grant && cand_in) begin
                mem[cand_wfid] <= cand_data;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Read ports with write-first bypass
    // ---------------------------------------------------------------------
    logic [NUM_RD-1:0] rd_oob;
    logic [DATA_W-1:0] rd_next [NUM_RD];

    for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
        logic [WFID_W-1:0] addr;
        assign addr      = rd_wfid[r*WFID_W +: WFID_W];
        assign rd_oob[r] = !in_range(addr);

        always_comb begin
            rd_next[r] = '0;
            if (rd_oob[r]) begin
                rd_next[r] = '0;
            end else if (grant && (cand_wfid == addr)) begin
                rd_next[r] = cand_data;
            end else if (init_en && (init_wfid == addr)) begin
                rd_next[r] = init_data;
            end else begin
                rd_next[r] = mem[addr];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_data  <= '0;
            rd_valid <= '0;
        end else begin
            rd_valid <= rd_en;
            for (int r = 0; r < NUM_RD; r++) begin
                if (rd_en[r]) begin
                    rd_data[r*DATA_W +: DATA_W] <= rd_next[r];
                end
            end
        end
    end

    // ---------------------------------------------------------------------
    // Sticky out-of-range flag
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            err_oob <= 1'b0;
        end else if ((init_en && !init_in) || (grant && !cand_in) || (|(rd_en & rd_oob))) begin
            err_oob <= 1'b1;
        end
    end

endmodule
